alu_exec: RTL and testbench
===========================

# alu_exec

Execute stage directly downstream of the ALU operand-select stage. Takes the registered operand pair and its enable pulse, performs the operation selected by the decoder's function code, and delivers a registered 16-bit result, NZCV flags and a one-cycle result-valid pulse to writeback.
- Logic, add/sub and shift operations complete in one cycle.
- MUL runs on an iterative 16-cycle shift-add engine, with a busy output that back-pressures the upstream stages.

## Interface
Parameters:
- WIDTH, 16, operand/result width (only 16 is verified)
- MUL_CYCLES, 16, iterations of the multiply engine (equals WIDTH)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en_in  input  1  operands valid this cycle (single-cycle pulse from operand-select stage)
- alu_a  input  16  operand A (rd value)
- alu_b  input  16  operand B (offset / rs / ldr offset)
- alu_func  input  3  operation code, sampled with en_in
- alu_out  output  16  registered result
- flags  output  4  {N,Z,C,V}, registered
- en_out  output  1  result valid, one-cycle pulse
- busy  output  1  multiply in progress; en_in ignored while high

## Operation
Function codes:
- 000 ADD: C = carry out; V = signed overflow
- 001 SUB (a-b): C = borrow (a<b unsigned); V = signed overflow
- 010 AND, 011 OR, 100 XOR: C=0, V=0
- 101 SHL by alu_b[3:0], 110 SHR logical by alu_b[3:0]: C=0, V=0
- 111 MUL: low 16 bits of the unsigned product; C=1 iff product[31:16]≠0; V=0

Flag rules:
- N = alu_out[15]; Z = (alu_out==0)
- flags and alu_out update only in the cycle en_out is asserted; both hold their values otherwise

State machine:
- IDLE: en_in with func≠111 → compute, register the result, pulse en_out; stay in IDLE.
- IDLE: en_in with func=111 → load multiplicand/multiplier, clear the 32-bit accumulator and the 4-bit counter, go to MUL_RUN.
- MUL_RUN: each cycle, if multiplier LSB=1 add the multiplicand to the accumulator; shift multiplicand left and multiplier right; counter++.
- MUL_RUN: after the 16th iteration, go to MUL_DONE.
- MUL_DONE: register the result and flags, pulse en_out, return to IDLE. en_in is accepted in this cycle, because busy is already low.

Boundary rules:
- en_in while busy=1: ignored entirely, with no state, output or flag change. Upstream must hold off.
- Shift amount 0: result = a.
- Unknown behaviour is not permitted: all 8 codes are defined.

Reset:
- Reset values: alu_out=0, flags=0, en_out=0, busy=0, state=IDLE, counter=0.
- Reset asserted at any time, including mid-MUL, aborts immediately. No en_out is produced for the aborted operation.

## Timing
- Single-cycle op: en_in sampled at edge T; alu_out/flags/en_out valid in cycle T+1. en_out is high for exactly one cycle.
- Back-to-back single-cycle ops are accepted on every cycle, giving one result per cycle.
- MUL: en_in sampled at edge T; busy=1 in cycles T+1..T+16 (MUL_RUN).
- MUL: in cycle T+17, en_out=1, busy=0, and the result and flags are valid.
- busy is registered and deasserts in the same cycle en_out rises.
- Throughput: one MUL every 17 cycles.

## Structure
- Shared package/header alu_defs holds:
  - the 3-bit op encodings (ALU_ADD … ALU_MUL)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
  - state encodings (IDLE, MUL_RUN, MUL_DONE)
- The decoder and writeback include alu_defs as well.
- Sub-module alu_mul_seq contains the shift-add datapath and iteration counter.
  - Interface: start, a, b → done, product[31:0].
  - alu_exec owns the FSM, the single-cycle datapath and the flag logic.

## Test plan
- ADD 0x7FFF + 0x0001 at T → cycle T+1: alu_out=0x8000, N=1 Z=0 C=0 V=1, en_out high exactly one cycle.
- SUB 0x0003 − 0x0005, then AND 0xF0F0 & 0x0FF0 on the next cycle → 0xFFFE with C=1 N=1, then 0x00F0 with flags 0000, on consecutive cycles.
- MUL 0x0123 × 0x0010 at T → busy high T+1..T+16; cycle T+17: alu_out=0x1230, C=0, en_out=1, busy=0.
- MUL 0x1000 × 0x0010 → 0x0000 with Z=1 C=1. An en_in ADD 1+1 issued at T+5 during busy is ignored, with no extra en_out. An ADD 1+1 issued at T+17 yields 0x0002 at T+18.
- Reset asserted at T+8 of a MUL → all outputs 0 immediately. After release, no en_out appears, and a fresh SHL 0x0001 by 4 gives 0x0010 one cycle after en_in.
- SHR 0x8000 by alu_b=0x0010 (amount 0) → 0x8000, N=1.

Source files
------------

// File: rtl/alu_defs.sv
// alu_defs: shared definitions for the ALU pipeline (decoder, execute, writeback).
//   - 3-bit operation encodings
//   - bit positions of the {N,Z,C,V} flags
//   - execute-stage FSM state encodings
package alu_defs;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } exec_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier.
//   clk, rst      : clock, async active-low reset
//   start_i       : load operands, clear accumulator and counter
//   a_i, b_i      : multiplicand, multiplier
//   done_o        : high during the last iteration cycle
//   product_o     : accumulator value after the current iteration
// product_o is the combinational next accumulator, so the final product is
// available in the same cycle done_o is high and can be registered by the
// caller on that edge without an extra cycle of latency.
module alu_mul_seq #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;
  logic [2*WIDTH-1:0] partial;

  always_comb begin
    partial   = mplr_q[0] ? mcand_q : '0;
    product_o = acc_q + partial;
    done_o    = run_q && (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q <= {{WIDTH{1'b0}}, a_i};
      mplr_q  <= b_i;
      acc_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      acc_q   <= product_o;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + CW'(1);
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: ALU execute stage.
//   clk, rst  : clock, async active-low reset
//   en_in     : operand pair valid (ignored while busy)
//   alu_a/b   : operands
//   alu_func  : operation code (alu_defs::alu_op_e)
//   alu_out   : registered result
//   flags     : registered {N,Z,C,V}
//   en_out    : one-cycle result-valid pulse
//   busy      : multiply in progress
//
// state    | meaning
// IDLE     | accepting ops; single-cycle ops complete here
// MUL_RUN  | shift-add engine iterating, busy high, en_in ignored
// MUL_DONE | multiply result presented; accepts en_in like IDLE
module alu_exec
  import alu_defs::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [2:0]       alu_func,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags,
  output logic             en_out,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  exec_state_e state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [3:0]       flags_q, flags_d;
  logic             en_out_q, en_out_d;
  logic             busy_q, busy_d;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] diff;
  alu_op_e          op;

  alu_mul_seq #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (alu_a),
    .b_i       (alu_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Single-cycle datapath
  always_comb begin
    op       = alu_op_e'(alu_func);
    add_full = {1'b0, alu_a} + {1'b0, alu_b};
    diff     = alu_a - alu_b;
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    case (op)
      ALU_ADD: begin
        res   = add_full[WIDTH-1:0];
        res_c = add_full[WIDTH];
        res_v = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_SUB: begin
        res   = diff;
        res_c = (alu_a < alu_b);
        res_v = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_AND: res = alu_a & alu_b;
      ALU_OR:  res = alu_a | alu_b;
      ALU_XOR: res = alu_a ^ alu_b;
      ALU_SHL: res = alu_a << alu_b[SHW-1:0];
      ALU_SHR: res = alu_a >> alu_b[SHW-1:0];
      default: res = '0;
    endcase
  end

  // FSM next-state and output-register update
  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    flags_d   = flags_q;
    en_out_d  = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      IDLE, MUL_DONE: begin
        state_d = IDLE;
        if (en_in) begin
          if (op == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL_RUN;
          end else begin
            alu_out_d       = res;
            flags_d[FLAG_N] = res[WIDTH-1];
            flags_d[FLAG_Z] = (res == '0);
            flags_d[FLAG_C] = res_c;
            flags_d[FLAG_V] = res_v;
            en_out_d        = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        if (mul_done) begin
          state_d         = MUL_DONE;
          alu_out_d       = mul_prod[WIDTH-1:0];
          flags_d[FLAG_N] = mul_prod[WIDTH-1];
          flags_d[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
          flags_d[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
          flags_d[FLAG_V] = 1'b0;
          en_out_d        = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MUL_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
      flags_q   <= '0;
      en_out_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      flags_q   <= flags_d;
      en_out_q  <= en_out_d;
      busy_q    <= busy_d;
    end
  end

  assign alu_out = alu_out_q;
  assign flags   = flags_q;
  assign en_out  = en_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  logic        clk;
  logic        rst;
  logic        en_in;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_func;
  logic [15:0] alu_out;
  logic [3:0]  flags;
  logic        en_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_exec #(.WIDTH(16), .MUL_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_in    (en_in),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_func (alu_func),
    .alu_out  (alu_out),
    .flags    (flags),
    .en_out   (en_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // MUL issued at the next negedge (sampled at edge T). Optionally injects an
  // ADD 1+1 at T+5 (must be ignored) and an ADD 1+1 at T+17 (must be accepted).
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_out, input logic [3:0] exp_flags,
                         input bit inject_busy, input bit follow_add);
    int bad_busy;
    bad_busy = 0;
    @(negedge clk);
    en_in = 1'b1; alu_func = 3'b111; alu_a = a; alu_b = b;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || en_out !== 1'b0) bad_busy++;
      en_in = 1'b0;
      if (inject_busy && c == 5) begin
        en_in = 1'b1; alu_func = 3'b000; alu_a = 16'h0001; alu_b = 16'h0001;
      end
    end
    check("mul_busy_window_bad_cycles", 32'(bad_busy), 32'd0);
    @(negedge clk);
    check("mul_en_out", {31'd0, en_out}, 32'd1);
    check("mul_busy_low", {31'd0, busy}, 32'd0);
    check("mul_result", {16'd0, alu_out}, {16'd0, exp_out});
    check("mul_flags", {28'd0, flags}, {28'd0, exp_flags});
    if (follow_add) begin
      en_in = 1'b1; alu_func = 3'b000; alu_a = 16'h0001; alu_b = 16'h0001;
    end
    @(negedge clk);
    en_in = 1'b0;
    if (follow_add) begin
      check("post_mul_add_en_out", {31'd0, en_out}, 32'd1);
      check("post_mul_add_result", {16'd0, alu_out}, 32'h0002);
      check("post_mul_add_flags", {28'd0, flags}, 32'h0);
      @(negedge clk);
    end
    check("mul_en_out_single", {31'd0, en_out}, 32'd0);
  endtask

  initial begin
    int stray;
    vecs[0]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'h9};
    vecs[1]  = '{3'b001, 16'h0003, 16'h0005, 16'hFFFE, 4'hA};
    vecs[2]  = '{3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'h0};
    vecs[3]  = '{3'b011, 16'hF000, 16'h000F, 16'hF00F, 4'h8};
    vecs[4]  = '{3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 4'h4};
    vecs[5]  = '{3'b101, 16'h0001, 16'h0004, 16'h0010, 4'h0};
    vecs[6]  = '{3'b110, 16'h8000, 16'h0010, 16'h8000, 4'h8};
    vecs[7]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'h6};
    vecs[8]  = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'h1};
    vecs[9]  = '{3'b101, 16'h8001, 16'h0001, 16'h0002, 4'h0};
    vecs[10] = '{3'b110, 16'hF000, 16'h0004, 16'h0F00, 4'h0};
    vecs[11] = '{3'b000, 16'h8000, 16'h8000, 16'h0000, 4'h7};
    vecs[12] = '{3'b001, 16'h0005, 16'h0005, 16'h0000, 4'h4};

    rst = 1'b0; en_in = 1'b0; alu_a = '0; alu_b = '0; alu_func = '0;
    #1;
    check("reset_out", {16'd0, alu_out}, 32'd0);
    check("reset_flags", {28'd0, flags}, 32'd0);
    check("reset_en_out", {31'd0, en_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Back-to-back single-cycle ops: one result per cycle
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("vec%0d_en_out", i-1), {31'd0, en_out}, 32'd1);
        check($sformatf("vec%0d_out", i-1), {16'd0, alu_out}, {16'd0, vecs[i-1].exp_out});
        check($sformatf("vec%0d_flags", i-1), {28'd0, flags}, {28'd0, vecs[i-1].exp_flags});
      end
      en_in = 1'b1; alu_func = vecs[i].func; alu_a = vecs[i].a; alu_b = vecs[i].b;
    end
    @(negedge clk);
    en_in = 1'b0;
    check("vec12_en_out", {31'd0, en_out}, 32'd1);
    check("vec12_out", {16'd0, alu_out}, {16'd0, vecs[12].exp_out});
    check("vec12_flags", {28'd0, flags}, {28'd0, vecs[12].exp_flags});
    @(negedge clk);
    check("en_out_one_cycle", {31'd0, en_out}, 32'd0);
    alu_a = 16'h1234; alu_b = 16'h4321; alu_func = 3'b000;
    @(negedge clk);
    check("hold_out", {16'd0, alu_out}, 32'h0000);
    check("hold_flags", {28'd0, flags}, 32'h4);

    run_mul(16'h0123, 16'h0010, 16'h1230, 4'h0, 1'b0, 1'b0);
    run_mul(16'h1000, 16'h0010, 16'h0000, 4'h6, 1'b1, 1'b1);
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 4'h2, 1'b0, 1'b0);

    // Reset in the middle of a MUL
    @(negedge clk);
    en_in = 1'b1; alu_func = 3'b111; alu_a = 16'h00FF; alu_b = 16'h00FF;
    @(negedge clk);
    en_in = 1'b0;
    repeat (7) @(negedge clk);
    check("midmul_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_out", {16'd0, alu_out}, 32'd0);
    check("abort_flags", {28'd0, flags}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_en_out", {31'd0, en_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (en_out !== 1'b0 || busy !== 1'b0) stray++;
    end
    check("abort_no_en_out", 32'(stray), 32'd0);
    en_in = 1'b1; alu_func = 3'b101; alu_a = 16'h0001; alu_b = 16'h0004;
    @(negedge clk);
    en_in = 1'b0;
    check("post_reset_shl_en_out", {31'd0, en_out}, 32'd1);
    check("post_reset_shl_out", {16'd0, alu_out}, 32'h0010);
    check("post_reset_shl_flags", {28'd0, flags}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
